// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode and parity-engine state encodings,
// plus the acc+mode -> parity bit mapping used by the engine and the TX framer.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } par_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_READY = 2'b10
   } state_t;

   // Map running XOR of the data bits onto the transmitted parity bit.
   // Mark and space are constant regardless of the data.
   function automatic logic parity_map(input logic acc, input par_mode_t mode);
      logic p;
      case (mode)
         PAR_EVEN:  p = acc;
         PAR_ODD:   p = ~acc;
         PAR_MARK:  p = 1'b1;
         PAR_SPACE: p = 1'b0;
         default:   p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_parity_mode_mux.sv
// Combinational parity-mode mapping: accumulated XOR plus latched mode to
// the parity bit. Kept separate so the TX framer can reuse it directly.
module uart_parity_mode_mux
   import uart_pkg::*;
(
   input  logic      acc,
   input  par_mode_t mode,
   output logic      parity
);

   logic parity_s;

   // Select parity bit from accumulator according to the frame's mode
   always_comb begin
      parity_s = 1'b0;
      parity_s = parity_map(acc, mode);
   end

   assign parity = parity_s;

endmodule

// File: rtl/uart_parity_engine.sv
// Serial UART parity generator/checker. Parity is accumulated one data bit
// at a time as the serializer/sampler moves bits, so no data register is
// kept. In READY the received parity bit is compared and mismatches are
// reported as a one-cycle pulse and a sticky flag.
module uart_parity_engine
   import uart_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             par_en,
   input  logic [1:0]       par_mode,
   input  logic [CNT_W-1:0] data_len,
   input  logic             frame_start,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             par_bit_valid,
   input  logic             par_bit_in,
   input  logic             err_clr,
   output logic             parity_out,
   output logic             parity_ready,
   output logic             par_err,
   output logic             par_err_sticky,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATAWIDTH);

   state_t           state_r;
   logic             acc_r;
   logic [CNT_W-1:0] bit_cnt_r;
   logic [CNT_W-1:0] len_r;
   par_mode_t        mode_r;
   logic             en_r;
   logic             parity_ready_r;
   logic             par_err_r;
   logic             sticky_r;

   logic [CNT_W-1:0] len_clamped_s;
   logic             last_bit_s;
   logic             mismatch_s;
   logic             parity_s;

   uart_parity_mode_mux u_mode_mux (
      .acc    (acc_r),
      .mode   (mode_r),
      .parity (parity_s)
   );

   // Out-of-range frame lengths (zero or above DATAWIDTH) fall back to the maximum
   always_comb begin
      len_clamped_s = MAX_LEN;
      if ((data_len == {CNT_W{1'b0}}) || (data_len > MAX_LEN)) begin
         len_clamped_s = MAX_LEN;
      end else begin
         len_clamped_s = data_len;
      end
   end

   // Decode last data bit and a received-parity mismatch in this cycle
   always_comb begin
      last_bit_s = 1'b0;
      mismatch_s = 1'b0;
      if (bit_cnt_r == (len_r - CNT_W'(1))) begin
         last_bit_s = 1'b1;
      end else begin
         last_bit_s = 1'b0;
      end
      // frame_start pre-empts the check, so a mismatch only counts without it
      if ((state_r == ST_READY) && par_bit_valid && !frame_start) begin
         mismatch_s = (par_bit_in != parity_s);
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Frame FSM with accumulator, bit counter and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         acc_r          <= 1'b0;
         bit_cnt_r      <= {CNT_W{1'b0}};
         len_r          <= {CNT_W{1'b0}};
         mode_r         <= PAR_EVEN;
         en_r           <= 1'b0;
         parity_ready_r <= 1'b0;
         par_err_r      <= 1'b0;
      end else begin
         par_err_r <= 1'b0;
         if (frame_start) begin
            state_r        <= ST_ACCUM;
            acc_r          <= 1'b0;
            bit_cnt_r      <= {CNT_W{1'b0}};
            len_r          <= len_clamped_s;
            mode_r         <= par_mode_t'(par_mode);
            en_r           <= par_en;
            parity_ready_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_ACCUM: begin
                  if (bit_valid) begin
                     acc_r     <= acc_r ^ bit_in;
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                     if (last_bit_s) begin
                        if (en_r) begin
                           state_r        <= ST_READY;
                           parity_ready_r <= 1'b1;
                        end else begin
                           state_r <= ST_IDLE;
                        end
                     end else begin
                        state_r <= ST_ACCUM;
                     end
                  end else begin
                     state_r <= ST_ACCUM;
                  end
               end
               ST_READY: begin
                  if (par_bit_valid) begin
                     par_err_r      <= mismatch_s;
                     state_r        <= ST_IDLE;
                     parity_ready_r <= 1'b0;
                  end else begin
                     state_r <= ST_READY;
                  end
               end
               default: begin
                  state_r        <= ST_IDLE;
                  parity_ready_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Sticky error flag: a new mismatch beats a simultaneous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sticky_r <= 1'b0;
      end else if (mismatch_s) begin
         sticky_r <= 1'b1;
      end else if (err_clr) begin
         sticky_r <= 1'b0;
      end else begin
         sticky_r <= sticky_r;
      end
   end

   assign parity_out     = parity_s;
   assign parity_ready   = parity_ready_r;
   assign par_err        = par_err_r;
   assign par_err_sticky = sticky_r;
   assign bit_cnt        = bit_cnt_r;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine. Expected parity bits are pushed
// to a scoreboard queue when a frame is driven and popped when the DUT
// raises parity_ready. Inputs change on negedge; outputs sampled on negedge.
module tb_uart_parity_engine;

   logic       clk;
   logic       rst;
   logic       par_en;
   logic [1:0] par_mode;
   logic [3:0] data_len;
   logic       frame_start;
   logic       bit_valid;
   logic       bit_in;
   logic       par_bit_valid;
   logic       par_bit_in;
   logic       err_clr;
   logic       parity_out;
   logic       parity_ready;
   logic       par_err;
   logic       par_err_sticky;
   logic [3:0] bit_cnt;

   int   vectors;
   int   miscompares;
   logic exp_q[$];
   logic exp_v;

   uart_parity_engine #(.DATAWIDTH(8), .CNT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .par_en         (par_en),
      .par_mode       (par_mode),
      .data_len       (data_len),
      .frame_start    (frame_start),
      .bit_valid      (bit_valid),
      .bit_in         (bit_in),
      .par_bit_valid  (par_bit_valid),
      .par_bit_in     (par_bit_in),
      .err_clr        (err_clr),
      .parity_out     (parity_out),
      .parity_ready   (parity_ready),
      .par_err        (par_err),
      .par_err_sticky (par_err_sticky),
      .bit_cnt        (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_len(input logic [3:0] len);
      if (len == 4'd0 || len > 4'd8) return 8;
      else return int'(len);
   endfunction

   function automatic logic model_par(input logic [14:0] bits, input int n, input logic [1:0] mode);
      logic x;
      x = 1'b0;
      for (int i = 0; i < n; i++) x = x ^ bits[i];
      case (mode)
         2'b00:   return x;
         2'b01:   return ~x;
         2'b10:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Stimulus tasks: entered and left on a negedge
   task automatic start_frame(input logic en, input logic [1:0] mode, input logic [3:0] len);
      par_en = en; par_mode = mode; data_len = len; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1; bit_in = b;
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   task automatic send_par(input logic b, input logic clr);
      par_bit_valid = 1'b1; par_bit_in = b; err_clr = clr;
      @(negedge clk);
      par_bit_valid = 1'b0; err_clr = 1'b0;
   endtask

   // Drive a complete frame, pushing the expected parity when enabled
   task automatic run_frame(input logic en, input logic [1:0] mode, input logic [3:0] len,
                            input logic [14:0] bits);
      int n;
      n = model_len(len);
      start_frame(en, mode, len);
      if (en) exp_q.push_back(model_par(bits, n, mode));
      for (int i = 0; i < n; i++) send_bit(bits[i]);
   endtask

   task automatic test_reset();
      rst = 1'b0; par_en = 1'b0; par_mode = 2'b00; data_len = 4'd0; frame_start = 1'b0;
      bit_valid = 1'b0; bit_in = 1'b0; par_bit_valid = 1'b0; par_bit_in = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (parity_out !== 1'b0) begin miscompares++; $display("FAIL reset_parity_out: got %b want 0", parity_out); end
      vectors++; if (parity_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", parity_ready); end
      vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", par_err); end
      vectors++; if (par_err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_sticky: got %b want 0", par_err_sticky); end
      vectors++; if (bit_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
   endtask

   task automatic test_even();
      logic [14:0] bits;
      bits = 15'b000_0000_0000_1101;   // bits 1,0,1,1,0,0,0,0
      start_frame(1'b1, 2'b00, 4'd8);
      exp_q.push_back(model_par(bits, 8, 2'b00));
      for (int i = 0; i < 7; i++) send_bit(bits[i]);
      vectors++; if (parity_ready !== 1'b0) begin miscompares++; $display("FAIL even_early_ready: got %b want 0", parity_ready); end
      send_bit(bits[7]);
      vectors++; if (parity_ready !== 1'b1) begin miscompares++; $display("FAIL even_ready: got %b want 1", parity_ready); end
      exp_v = exp_q.pop_front();
      vectors++; if (parity_out !== exp_v || exp_v !== 1'b1) begin miscompares++; $display("FAIL even_parity: got %b want %b", parity_out, exp_v); end
      vectors++; if (bit_cnt !== 4'd8) begin miscompares++; $display("FAIL even_bit_cnt: got %0d want 8", bit_cnt); end
      repeat (2) @(negedge clk);
      vectors++; if (parity_ready !== 1'b1 || parity_out !== 1'b1) begin miscompares++; $display("FAIL even_hold: got rdy=%b par=%b want 1 1", parity_ready, parity_out); end
      send_par(1'b1, 1'b0);
   endtask

   task automatic test_odd();
      run_frame(1'b1, 2'b01, 4'd5, 15'b000_0000_0000_0011);
      vectors++; if (parity_ready !== 1'b1) begin miscompares++; $display("FAIL odd_ready: got %b want 1", parity_ready); end
      exp_v = exp_q.pop_front();
      vectors++; if (parity_out !== exp_v || exp_v !== 1'b1) begin miscompares++; $display("FAIL odd_parity: got %b want %b", parity_out, exp_v); end
      send_par(1'b0, 1'b0);
      vectors++; if (par_err !== 1'b1) begin miscompares++; $display("FAIL odd_err_pulse: got %b want 1", par_err); end
      vectors++; if (par_err_sticky !== 1'b1) begin miscompares++; $display("FAIL odd_sticky: got %b want 1", par_err_sticky); end
      vectors++; if (parity_ready !== 1'b0) begin miscompares++; $display("FAIL odd_ready_clr: got %b want 0", parity_ready); end
      @(negedge clk);
      vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL odd_err_width: got %b want 0", par_err); end
   endtask

   task automatic test_mark_space();
      logic [1:0] m;
      for (int k = 0; k < 2; k++) begin
         m = (k == 0) ? 2'b10 : 2'b11;
         run_frame(1'b1, m, 4'd8, 15'h00FF);
         exp_v = exp_q.pop_front();
         vectors++; if (parity_ready !== 1'b1 || parity_out !== exp_v) begin miscompares++; $display("FAIL mark_space_%0d: got rdy=%b par=%b want 1 %b", k, parity_ready, parity_out, exp_v); end
         send_par(exp_v, 1'b0);
         vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL mark_space_err_%0d: got %b want 0", k, par_err); end
      end
   endtask

   task automatic test_no_parity();
      int seen;
      seen = 0;
      run_frame(1'b0, 2'b00, 4'd8, 15'h0055);
      for (int i = 0; i < 4; i++) begin
         if (parity_ready === 1'b1) seen++;
         @(negedge clk);
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL nopar_ready: got %0d ready cycles want 0", seen); end
      vectors++; if (bit_cnt !== 4'd8) begin miscompares++; $display("FAIL nopar_bit_cnt: got %0d want 8", bit_cnt); end
      send_par(1'b1, 1'b0);
      vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL nopar_err: got %b want 0", par_err); end
   endtask

   task automatic test_clamp();
      logic [3:0]  lens [2];
      logic [14:0] bits;
      lens[0] = 4'd0; lens[1] = 4'd12;
      for (int k = 0; k < 2; k++) begin
         bits = 15'($urandom);
         start_frame(1'b1, 2'b00, lens[k]);
         exp_q.push_back(model_par(bits, 8, 2'b00));
         for (int i = 0; i < 7; i++) send_bit(bits[i]);
         vectors++; if (parity_ready !== 1'b0) begin miscompares++; $display("FAIL clamp_early_%0d: got %b want 0", k, parity_ready); end
         send_bit(bits[7]);
         exp_v = exp_q.pop_front();
         vectors++; if (parity_ready !== 1'b1 || parity_out !== exp_v || bit_cnt !== 4'd8) begin
            miscompares++; $display("FAIL clamp_%0d: got rdy=%b par=%b cnt=%0d want 1 %b 8", k, parity_ready, parity_out, bit_cnt, exp_v);
         end
         send_par(exp_v, 1'b0);
      end
   endtask

   task automatic test_restart();
      start_frame(1'b1, 2'b00, 4'd8);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      vectors++; if (bit_cnt !== 4'd3) begin miscompares++; $display("FAIL restart_mid_cnt: got %0d want 3", bit_cnt); end
      bit_valid = 1'b1; bit_in = 1'b1;   // must be ignored alongside frame_start
      start_frame(1'b1, 2'b00, 4'd4);
      bit_valid = 1'b0;
      vectors++; if (bit_cnt !== 4'd0 || parity_ready !== 1'b0 || parity_out !== 1'b0) begin
         miscompares++; $display("FAIL restart_clear: got cnt=%0d rdy=%b par=%b want 0 0 0", bit_cnt, parity_ready, parity_out);
      end
      exp_q.push_back(model_par(15'b0001, 4, 2'b00));
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      exp_v = exp_q.pop_front();
      vectors++; if (parity_ready !== 1'b1 || parity_out !== exp_v || bit_cnt !== 4'd4) begin
         miscompares++; $display("FAIL restart_frame: got rdy=%b par=%b cnt=%0d want 1 %b 4", parity_ready, parity_out, bit_cnt, exp_v);
      end
      send_par(exp_v, 1'b0);
   endtask

   task automatic test_sticky();
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      vectors++; if (par_err_sticky !== 1'b0) begin miscompares++; $display("FAIL sticky_pre_clr: got %b want 0", par_err_sticky); end
      run_frame(1'b1, 2'b00, 4'd2, 15'b01);
      exp_v = exp_q.pop_front();
      send_par(~exp_v, 1'b1);
      vectors++; if (par_err_sticky !== 1'b1 || par_err !== 1'b1) begin miscompares++; $display("FAIL sticky_clr_race: got sticky=%b err=%b want 1 1", par_err_sticky, par_err); end
      @(negedge clk);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      vectors++; if (par_err_sticky !== 1'b0) begin miscompares++; $display("FAIL sticky_clr: got %b want 0", par_err_sticky); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  m;
      logic [3:0]  len;
      logic [14:0] bits;
      for (int k = 0; k < 6; k++) begin
         m    = 2'($urandom_range(0, 1));
         len  = 4'($urandom_range(1, 8));
         bits = 15'($urandom);
         run_frame(1'b1, m, len, bits);
         exp_v = exp_q.pop_front();
         vectors++; if (parity_ready !== 1'b1 || parity_out !== exp_v || bit_cnt !== len) begin
            miscompares++; $display("FAIL b2b_%0d: got rdy=%b par=%b cnt=%0d want 1 %b %0d", k, parity_ready, parity_out, bit_cnt, exp_v, len);
         end
         send_par(exp_v, 1'b0);
         vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL b2b_err_%0d: got %b want 0", k, par_err); end
      end
   endtask

   task automatic test_reset_mid();
      start_frame(1'b1, 2'b00, 4'd8);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      vectors++; if (parity_out !== 1'b1 || bit_cnt !== 4'd3) begin miscompares++; $display("FAIL rstmid_pre: got par=%b cnt=%0d want 1 3", parity_out, bit_cnt); end
      #2 rst = 1'b0;
      #1;
      vectors++; if ({parity_out, parity_ready, par_err, par_err_sticky, bit_cnt} !== 8'h00) begin
         miscompares++; $display("FAIL rstmid_async: got par=%b rdy=%b err=%b sticky=%b cnt=%0d want all 0",
                                 parity_out, parity_ready, par_err, par_err_sticky, bit_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_even();
      test_odd();
      test_mark_space();
      test_no_parity();
      test_clamp();
      test_restart();
      test_sticky();
      test_back_to_back();
      test_reset_mid();
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
